// File: rtl/rv32i_fetch_unit.sv
// rv32i_fetch_unit: RV32I instruction fetch stage.
// Holds the fetch PC, issues word requests to instruction memory, buffers
// returned words with their PCs in an in-order queue and presents them to
// decode. Redirects flush the queue and discard responses still in flight.
//
// Parameters:
//   RESET_PC    fetch PC loaded on reset (word aligned)
//   FIFO_DEPTH  queue entries and maximum in-flight requests (power of two, >= 2)
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   imem_req_valid/addr/ready          request channel to instruction memory
//   imem_rsp_valid/data                in-order response channel (no stall)
//   redirect_valid/redirect_pc         control-flow redirect from execute
//   instr_valid/instr/instr_pc/ready   queue head presented to decode
module rv32i_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  entry_t           queue_q [FIFO_DEPTH];
  entry_t           queue_d [FIFO_DEPTH];

  logic             pop;
  logic             push;
  logic             req_fire;
  logic             rsp_arrival;
  logic             rsp_drop;
  logic [SUM_W-1:0] credit_used;
  logic [31:0]      redirect_target;
  logic             unused_redirect_lsbs;

  // Low redirect bits are ignored by definition.
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign redirect_target      = {redirect_pc[31:2], 2'b00};

  // Head presentation; outputs read as zero whenever the queue is empty.
  assign instr_valid   = (count_q != '0);
  assign instr         = instr_valid ? queue_q[head_q].word : 32'h0;
  assign instr_pc      = instr_valid ? queue_q[head_q].pc   : 32'h0;
  assign imem_req_addr = fetch_pc_q;

  // Handshake decode, credit check and next-state computation.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    count_d       = count_q;
    head_d        = head_q;
    tail_d        = tail_q;
    queue_d       = queue_q;

    pop = instr_valid && instr_ready;

    // A response with nothing outstanding (e.g. straggler across reset) is ignored.
    rsp_arrival = imem_rsp_valid && (outstanding_q != '0);
    rsp_drop    = rsp_arrival && (drop_cnt_q != '0);
    push        = rsp_arrival && (drop_cnt_q == '0) && !redirect_valid;

    // Stale requests still hold credit until they return.
    credit_used    = SUM_W'(outstanding_q) + SUM_W'(count_q) - SUM_W'(pop);
    imem_req_valid = rst_n && !redirect_valid && (credit_used < SUM_W'(FIFO_DEPTH));
    req_fire       = imem_req_valid && imem_req_ready;

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_arrival);

    if (rsp_drop) begin
      drop_cnt_d = drop_cnt_q - CNT_W'(1);
    end

    if (push) begin
      queue_d[tail_q] = '{pc: rsp_pc_q, word: imem_rsp_data};
      tail_d          = tail_q + PTR_W'(1);
      rsp_pc_d        = rsp_pc_q + 32'd4;
    end

    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    // Redirect: flush, retarget both PCs, and mark every in-flight request
    // (minus the one returning now) as stale. drop_cnt never exceeds
    // outstanding, so this covers requests from earlier redirects too.
    if (redirect_valid) begin
      fetch_pc_d = redirect_target;
      rsp_pc_d   = redirect_target;
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      drop_cnt_d = outstanding_q - CNT_W'(rsp_arrival);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      queue_q       <= '{default: '0};
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      queue_q       <= queue_d;
    end
  end

endmodule
